// File: rtl/spi_fsm.sv
// rtl/spi_fsm.sv - SPI memory transaction controller: address byte, then read-shift or write-commit of one data byte.
// Moore FSM; outputs decode from the registered state only.
module spi_fsm #(
    parameter int WORD_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_posedge,
    input  logic sclk_negedge,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_buff
);

    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_RECV,
        WRITE_COMMIT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Chip-select release aborts from anywhere and outranks every edge pulse.
    always_comb begin
        state_nx = state;
        count_nx = count;
        if (state != IDLE && cs_n) begin
            state_nx = IDLE;
            count_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_n) begin
                        state_nx = GET_ADDR;
                        count_nx = '0;
                    end
                end
                GET_ADDR: begin
                    if (sclk_posedge) begin
                        if (count == LAST) begin
                            state_nx = GOT_ADDR;
                            count_nx = '0;
                        end else begin
                            count_nx = count + CW'(1);
                        end
                    end
                end
                GOT_ADDR:     state_nx = rw_bit ? READ_LOAD : WRITE_RECV;
                READ_LOAD:    state_nx = READ_SHIFT;
                READ_SHIFT: begin
                    if (sclk_negedge) begin
                        if (count == LAST) begin
                            state_nx = DONE;
                            count_nx = '0;
                        end else begin
                            count_nx = count + CW'(1);
                        end
                    end
                end
                WRITE_RECV: begin
                    if (sclk_posedge) begin
                        if (count == LAST) begin
                            state_nx = WRITE_COMMIT;
                            count_nx = '0;
                        end else begin
                            count_nx = count + CW'(1);
                        end
                    end
                end
                WRITE_COMMIT: state_nx = DONE;
                DONE:         state_nx = DONE;
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            endcase
        end
    end

    always_comb begin
        addr_we   = 1'b0;
        sr_we     = 1'b0;
        dm_we     = 1'b0;
        miso_buff = 1'b0;
        case (state)
            GOT_ADDR:     addr_we   = 1'b1;
            READ_LOAD:    sr_we     = 1'b1;
            READ_SHIFT:   miso_buff = 1'b1;
            WRITE_COMMIT: dm_we     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_fsm.sv
// tb/tb_spi_fsm.sv - scoreboard bench for spi_fsm driven from randomized SCLK edge schedules.
module tb_spi_fsm;

    localparam int WB = 8;

    logic clk = 1'b0;
    logic reset;
    logic cs_n;
    logic sclk_posedge;
    logic sclk_negedge;
    logic rw_bit;
    logic addr_we;
    logic sr_we;
    logic dm_we;
    logic miso_buff;

    spi_fsm #(.WORD_BITS(WB)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_n         (cs_n),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .rw_bit       (rw_bit),
        .addr_we      (addr_we),
        .sr_we        (sr_we),
        .dm_we        (dm_we),
        .miso_buff    (miso_buff)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] outs;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   len;
    int   reset_cut;
    bit   pos_a[512];
    bit   neg_a[512];
    bit   csn_a[512];
    bit   rwb_a[512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: any cycle with an output asserted must match the next expected event.
    logic [3:0] mon_o;
    ev_t        mon_e;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_o = {addr_we, sr_we, dm_we, miso_buff};
            if (mon_o !== 4'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {28'b0, mon_o}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("event_outputs", {28'b0, mon_o}, {28'b0, mon_e.outs});
                end
            end
        end
    end

    // Edge schedule: cycle 0 idle, cs_n falls in cycle 1, SCLK edges at least 3 clk apart.
    task automatic build(input int abort_edge, input int extra, input bit lead_neg, input bit pos_at_fall);
        int c;
        int n_edges;
        int ka;
        for (int i = 0; i < 512; i++) begin
            pos_a[i] = 1'b0;
            neg_a[i] = 1'b0;
            csn_a[i] = 1'b1;
            rwb_a[i] = 1'($urandom);
        end
        c = 1;
        if (pos_at_fall) pos_a[1] = 1'b1;
        n_edges = 2 * WB * 2 + 2 * extra + (lead_neg ? 1 : 0);
        for (int k = 0; k < n_edges; k++) begin
            if (k == abort_edge) break;
            c += $urandom_range(3, 5);
            if (lead_neg ? (k % 2 == 1) : (k % 2 == 0)) pos_a[c] = 1'b1;
            else                                        neg_a[c] = 1'b1;
        end
        ka = c + $urandom_range(1, 4);
        for (int i = 1; i < ka; i++) csn_a[i] = 1'b0;
        len = ka + 3;
    endtask

    task automatic push(input int base, input int c, input int ka, input int lim, input logic [3:0] o);
        ev_t e;
        if (c <= ka && c < lim) begin
            e.cyc  = base + c;
            e.outs = o;
            exp_q.push_back(e);
        end
    endtask

    // Reference timeline: 8th address posedge N -> addr_we N+1; read: sr_we N+2, miso N+3..M;
    // write: dm_we at M+1. Nothing after the cs_n-high cycle ka is driven.
    task automatic model(input int base, input int lim, input bit rw);
        int ka;
        int n;
        int m;
        int cnt;
        int last;
        ka = len;
        for (int c = 2; c < len; c++) begin
            if (csn_a[c]) begin
                ka = c;
                break;
            end
        end
        n = -1;
        cnt = 0;
        reset_cut = -1;
        for (int c = 2; c < ka; c++) begin
            if (pos_a[c]) cnt++;
            if (cnt == WB) begin
                n = c;
                break;
            end
        end
        if (n < 0) return;
        rwb_a[n+1] = rw;
        push(base, n + 1, ka, lim, 4'b1000);
        m = -1;
        cnt = 0;
        if (rw) begin
            push(base, n + 2, ka, lim, 4'b0100);
            for (int c = n + 3; c < ka && m < 0; c++) begin
                if (neg_a[c]) cnt++;
                if (neg_a[c] && cnt == 3) reset_cut = c;
                if (cnt == WB) m = c;
            end
            last = (m < 0) ? ka : m;
            for (int c = n + 3; c <= last; c++) push(base, c, ka, lim, 4'b0001);
        end else begin
            for (int c = n + 2; c < ka && m < 0; c++) begin
                if (pos_a[c]) cnt++;
                if (cnt == WB) m = c;
            end
            if (m >= 0) push(base, m + 1, ka, lim, 4'b0010);
        end
    endtask

    task automatic play(input int stop);
        for (int c = 0; c < stop; c++) begin
            cs_n         = csn_a[c];
            sclk_posedge = pos_a[c];
            sclk_negedge = neg_a[c];
            rw_bit       = rwb_a[c];
            step();
        end
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
    endtask

    task automatic run(input bit rw, input int abort_edge, input int extra, input bit lead_neg, input bit pos_fall);
        int base;
        build(abort_edge, extra, lead_neg, pos_fall);
        base = cyc;
        model(base, 1 << 30, rw);
        play(len);
    endtask

    initial begin
        int base;
        reset        = 1'b1;
        cs_n         = 1'b1;
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
        rw_bit       = 1'b0;
        #1;
        chk("reset_state", {28'b0, addr_we, sr_we, dm_we, miso_buff}, 32'h0);
        step();
        step();
        reset = 1'b0;
        step();

        // Write to 0x15 (byte 0010101_0), read from 0x15 (byte 0010101_1).
        run(1'b0, -1, 0, 1'b0, 1'b0);
        run(1'b1, -1, 0, 1'b0, 1'b0);
        // Abort after 5 address posedges, then a fresh transaction.
        run(1'b0, 9, 0, 1'b0, 1'b0);
        run(1'b1, -1, 0, 1'b0, 1'b0);
        // Abort in READ_SHIFT after 3 data negedges.
        run(1'b1, 20, 0, 1'b0, 1'b0);
        // Write with 4 extra SCLK cycles after the data byte.
        run(1'b0, -1, 4, 1'b0, 1'b0);
        // Posedge in the cs_n-fall cycle and a leading negedge must not count.
        run(1'b0, -1, 0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of READ_SHIFT.
        build(-1, 0, 1'b0, 1'b0);
        base = cyc;
        model(base, 1 << 30, 1'b1);
        exp_q.delete();
        model(base, reset_cut + 2, 1'b1);
        play(reset_cut + 2);
        chk("miso_before_reset", {31'b0, miso_buff}, 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_async", {28'b0, addr_we, sr_we, dm_we, miso_buff}, 32'h0);
        cs_n = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        run(1'b0, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            run(1'($urandom),
                ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 36)),
                int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
        end

        cs_n = 1'b1;
        step();
        step();
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

Transaction controller for the SPI memory peripheral. It consumes the conditioned chip-select and the one-cycle SCLK edge pulses produced by the input conditioners, and sequences the rest of the peripheral: the shift register parallel load, the address latch, the data-memory write enable and the MISO tri-state buffer enable. Each transaction is one address byte followed by one data byte. The address byte is a 7-bit address plus an R/W bit in the LSB (1 = read, 0 = write).

## Interface
- WORD_BITS, 8, bits per address byte and per data byte; the SCLK edge counter is $clog2(WORD_BITS+1) bits wide.

- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE, counter 0 and all outputs 0.
- cs_n  input  1  conditioned chip select, active-low.
- sclk_posedge  input  1  one-clk pulse per SCLK rising edge (conditioner positiveedge).
- sclk_negedge  input  1  one-clk pulse per SCLK falling edge (conditioner negativeedge).
- rw_bit  input  1  shift register parallelDataOut[0]; sampled only in GOT_ADDR.
- addr_we  output  1  address latch write enable, 1-clk pulse.
- sr_we  output  1  shift register parallel-load enable, 1-clk pulse.
- dm_we  output  1  data memory write enable, 1-clk pulse.
- miso_buff  output  1  MISO tri-state driver enable, level.

## Operation
- Moore machine: outputs decode from the registered state only; there is no combinational path from inputs to outputs.
- State outputs: IDLE, GET_ADDR, WRITE_RECV and DONE drive all outputs 0.
  - GOT_ADDR drives addr_we=1.
  - READ_LOAD drives sr_we=1.
  - READ_SHIFT drives miso_buff=1.
  - WRITE_COMMIT drives dm_we=1.
- Abort rule: cs_n=1 in any state other than IDLE moves to IDLE next clk and clears the counter. Abort has priority over every edge pulse and transition.
- Transitions:
  - IDLE: cs_n=0 goes to GET_ADDR, counter=0.
  - GET_ADDR: each sclk_posedge increments the counter. The pulse that brings it to WORD_BITS goes to GOT_ADDR and clears the counter.
  - GOT_ADDR (1 clk): rw_bit=1 goes to READ_LOAD; rw_bit=0 goes to WRITE_RECV.
  - READ_LOAD (1 clk): goes to READ_SHIFT.
  - READ_SHIFT: each sclk_negedge increments the counter. The WORD_BITS-th pulse goes to DONE and clears the counter.
  - WRITE_RECV: each sclk_posedge increments the counter. The WORD_BITS-th pulse goes to WRITE_COMMIT and clears the counter.
  - WRITE_COMMIT (1 clk): goes to DONE.
  - DONE: holds until cs_n=1, then goes to IDLE.
- Ignored pulses:
  - Edge pulses in IDLE, GOT_ADDR, READ_LOAD, WRITE_COMMIT and DONE are ignored.
  - sclk_negedge is ignored in GET_ADDR and WRITE_RECV.
  - sclk_posedge is ignored in READ_SHIFT.
- sclk_posedge and sclk_negedge in the same clk: only the pulse relevant to the current state counts.
- Extra SCLK edges after DONE have no effect. Each write transaction produces exactly one dm_we pulse.

## Timing
- Reset values: state IDLE, counter 0, addr_we=sr_we=dm_we=miso_buff=0. Reset is effective immediately, including mid-transaction.
- Let the final address sclk_posedge pulse occur in clk cycle N:
  - GOT_ADDR (addr_we) is in N+1; rw_bit is valid there because the shift register captured the last bit in N.
  - Read path: READ_LOAD (sr_we) is in N+2, and miso_buff rises in N+3.
  - Write path: WRITE_RECV starts in N+2.
- Final data pulse in cycle M:
  - Read: the WORD_BITS-th sclk_negedge in M drops miso_buff in M+1 (DONE).
  - Write: WRITE_COMMIT (dm_we) is in M+1, DONE in M+2.
- cs_n rises in cycle K: IDLE in K+1 with all outputs 0. If the state in K was a pulse state, that cycle's pulse has already been driven.
- cs_n falling in K while IDLE: GET_ADDR in K+1. An sclk_posedge in K is not counted.
- Integration requirement: SCLK edges must be at least 3 clk apart, so no data edge lands in a single-cycle state.

## Test plan
- Reset mid-READ_SHIFT: assert reset with no clk edge -> all outputs 0 immediately; after release, state IDLE and counter 0.
- Write of address 0x15: cs_n=0, 8 posedges with bits 0010101_0, then 8 posedges with data 0xA5, then cs_n=1.
  - Required: addr_we pulses once, one clk after the 8th posedge.
  - Required: dm_we pulses exactly once, one clk after the 16th posedge.
  - Required: sr_we and miso_buff stay 0 throughout.
- Read of address 0x15 (byte 0010101_1):
  - Required: addr_we at N+1, sr_we at N+2, miso_buff high from N+3.
  - Required: miso_buff stays high through 7 negedges and falls one clk after the 8th negedge.
  - Required: dm_we never asserts.
- Abort after 5 address posedges (cs_n=1):
  - Required: IDLE next clk, no addr_we.
  - Required: a new transaction then behaves as a fresh one, with the counter restarted at 0.
- Abort during READ_SHIFT after 3 negedges -> miso_buff falls the clk after cs_n rises; no further outputs.
- Write transaction followed by 4 extra posedges before cs_n=1 -> single dm_we only; DONE holds until cs_n=1, then IDLE.
